vga_image_sequencer: RTL and testbench
======================================

# vga_image_sequencer

Selects which stored image the VGA display driver shows by generating its 3-bit image-enable code. Takes two raw push-buttons (next/prev), an optional automatic slideshow and a blank request. Every change is applied only at a frame boundary, detected as the falling edge of the driver's `vsync`, so a picture never switches mid-frame. Sits between the board buttons/switches and the driver's `ena[2:0]` input, in the `vga_clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: stable-level cycles a button needs before it is accepted (10 ms at 25 MHz).
- `DWELL_FRAMES`, default 180: frames each image is shown in auto mode (3 s at 60 Hz).
- `vga_clk`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_next`  in  1  raw, asynchronous button, active high.
- `btn_prev`  in  1  raw, asynchronous button, active high.
- `auto_mode`  in  1  level; enables the slideshow (used only with `SEQ_AUTO_EN`).
- `blank_req`  in  1  level; requests a white screen.
- `vsync`  in  1  driver sync; low for the first 5 lines of each frame.
- `ena`  out  3  image code to the driver: 3'b000 blank, 3'b001 image 0, 3'b011 image 1, 3'b111 image 2.
- `image_idx`  out  2  currently displayed index, 0–2.
- `pending`  out  1  high while a change is waiting for a frame boundary.

## Operation
- **Button input path**
  - 2-flop synchronizer on each button.
  - Per-button debounce counter, `$clog2(DEBOUNCE_CYCLES+1)` bits.
    - Resets to 0 whenever the synchronized level differs from the debounced level.
    - When it reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronized level and the counter clears.
  - Press event: a 1-cycle pulse on the debounced 0→1 transition.
- **Frame boundary:** `fb = vsync_d & ~vsync`, where `vsync_d` is `vsync` registered once.
- **Registers:**
  - `cur_idx`: displayed index.
  - `tgt_idx`: requested index.
  - `tgt_blank`: requested blank state.
  - Dwell counter: 8 bits minimum, sized to `DWELL_FRAMES`.
- **Index arithmetic** (mod 3):
  - next: 2→0, otherwise +1.
  - prev: 0→2, otherwise −1.
  - Each step is applied to `tgt_idx`, so several presses inside one frame accumulate.
- **State machine:**
  - INIT: entered from reset. On `fb`: `cur_idx = tgt_idx = 0`, go to SHOW.
  - SHOW: on any request (press, auto step, or `blank_req` differing from the current blank state), update the targets and go to WAIT.
  - WAIT: further requests keep updating the targets. On `fb`: copy the targets to the current registers, go to SHOW.
- **Priorities and ties:**
  - Next and prev pressed in the same cycle: both ignored.
  - A button press in the same cycle as an auto step: the press wins, the auto step is dropped, and the dwell counter clears.
  - A request arriving in the same cycle as `fb` while in SHOW is taken on the following `fb`.
- **Blank:**
  - While `blank_req` is high: index changes are still tracked in `tgt_idx`, `ena = 000`, and the dwell counter holds.
  - Releasing `blank_req` restores `ena` for `tgt_idx` at the next `fb`.
- **Outputs:**
  - `ena` and `image_idx` are registered, and derived only from the current registers.
  - `pending = (state == WAIT)`.

## Timing
- **Reset values:** `ena = 3'b000`, `image_idx = 0`, `pending = 0`, state INIT, all counters 0, debounced levels 0.
- **Frame-boundary latency:** `fb` is high in the cycle after `vsync` is first sampled low. `ena` and `image_idx` change on the clock edge at the end of that `fb` cycle, then stay constant until the next `fb`.
- **Button latency:** from a clean button edge to the press pulse is `2 + DEBOUNCE_CYCLES + 1` cycles. A glitch shorter than `DEBOUNCE_CYCLES` produces no pulse.
- **Reset mid-operation:** asynchronous assertion forces the reset values immediately. A request that was pending is discarded.
- **`vsync` low at reset release:** no `fb` is generated until the next falling edge.

## Configuration
- **`SEQ_AUTO_EN` defined:**
  - In SHOW with `auto_mode` high and `blank_req` low, the dwell counter increments on each `fb`.
  - On reaching `DWELL_FRAMES`, the counter clears and a next-step request is issued.
  - The request is applied at the following `fb`; the step frame itself counts as frame 0 of the new image.
  - The counter clears when `auto_mode` is low.
- **`SEQ_AUTO_EN` undefined:**
  - The dwell counter is not built and `auto_mode` is ignored.
  - Only buttons and `blank_req` change the image.

## Test plan
- **Reset, then startup:** reset, then one `vsync` falling edge. `ena` stays 000 until the `fb` cycle, then becomes 001 with `image_idx = 0`.
- **Next presses, wrap-around:** `DEBOUNCE_CYCLES = 4`; three debounced next presses, each in a separate frame. `ena` follows 011 → 111 → 001, each change aligned to `fb`, with `pending` high between press and `fb`.
- **Bounce filtering and accumulation:**
  - A 3-cycle glitch on `btn_prev` gives no change.
  - A clean prev press from index 0 gives `ena = 111` at the next `fb`.
  - Two prev presses within one frame from index 0 give index 1 (`ena = 011`).
- **Simultaneous presses:** next and prev debounced in the same cycle leave `ena` and `pending` unchanged.
- **Blank:**
  - `blank_req` high at index 1 gives `ena = 000` at the next `fb`.
  - A next press while blanked, then `blank_req` low, gives `ena = 111` at the following `fb`.
- **Auto mode (`SEQ_AUTO_EN`, `DWELL_FRAMES = 3`, `auto_mode = 1`):**
  - The index advances every 4th `fb` (3 dwell frames plus the apply frame).
  - A button press mid-dwell restarts the count.
  - Asserting reset mid-dwell returns `ena` to 000 immediately.

Source files
------------

// File: rtl/vga_image_sequencer.sv
// vga_image_sequencer
//
// Chooses which stored image the VGA driver shows by producing its 3-bit
// image-enable code. Requests come from two raw push-buttons (next/prev), an
// optional automatic slideshow and a blank request. A change is committed only
// at a frame boundary (falling edge of the driver's vsync), so a picture never
// switches mid-frame. Everything runs in the vga_clk domain.
//
// Optional feature: define SEQ_AUTO_EN to build the slideshow dwell counter.
// Without it, auto_mode is ignored and only buttons / blank_req act.
//
// Parameters
//   DEBOUNCE_CYCLES  stable-level cycles before a button level is accepted
//   DWELL_FRAMES     frames each image is shown in auto mode
//
// Ports
//   vga_clk    in   pixel clock, the only clock
//   rst_n      in   asynchronous active-low reset
//   btn_next   in   raw asynchronous button, active high
//   btn_prev   in   raw asynchronous button, active high
//   auto_mode  in   level, enables the slideshow (SEQ_AUTO_EN builds only)
//   blank_req  in   level, requests a white screen
//   vsync      in   driver sync, low for the first lines of each frame
//   ena        out  image code: 000 blank, 001 img0, 011 img1, 111 img2
//   image_idx  out  currently displayed index 0..2
//   pending    out  high while a change waits for a frame boundary
//   dbg_state  out  raw FSM state (0 INIT, 1 SHOW, 2 WAIT) for observation
//
// Handshake note: there is no valid/ready pairing here. A request is a
// single-cycle event (button press pulse, auto step) or a level difference
// (blank_req vs current blank state); it is latched into the target registers
// the cycle it appears and is consumed at the next frame boundary.

module vga_image_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DWELL_FRAMES    = 180
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       auto_mode,
  input  logic       blank_req,
  input  logic       vsync,
  output logic [2:0] ena,
  output logic [1:0] image_idx,
  output logic       pending,
  output logic [1:0] dbg_state
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_SHOW = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  function automatic logic [1:0] idx_inc(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [1:0] idx_dec(input logic [1:0] idx);
    return (idx == 2'd0) ? 2'd2 : idx - 2'd1;
  endfunction

  function automatic logic [2:0] ena_code(input logic [1:0] idx, input logic blank);
    logic [2:0] code;
    if (blank) begin
      code = 3'b000;
    end else begin
      case (idx)
        2'd0:    code = 3'b001;
        2'd1:    code = 3'b011;
        default: code = 3'b111;
      endcase
    end
    return code;
  endfunction

  // ---------------------------------------------------------------------------
  // Button path: bit 0 = next, bit 1 = prev
  // ---------------------------------------------------------------------------
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      db_q, db_d;
  logic [1:0]      press_q, press_d;
  logic [DB_W-1:0] cnt_q [2];
  logic [DB_W-1:0] cnt_d [2];

  assign btn_raw = {btn_prev, btn_next};

  // The counter only runs while the synchronized level disagrees with the
  // accepted level; any return to agreement (a bounce) restarts it from 0.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]   = cnt_q[i];
      db_d[i]    = db_q[i];
      press_d[i] = 1'b0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_MAX) begin
          cnt_d[i]   = '0;
          db_d[i]    = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      press_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      press_q <= press_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Frame boundary. vsync_q resets low so a vsync already low at reset
  // release cannot produce a boundary until its next falling edge.
  // ---------------------------------------------------------------------------
  logic vsync_q;
  logic fb;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) vsync_q <= 1'b0;
    else        vsync_q <= vsync;
  end

  assign fb = vsync_q & ~vsync;

  // Simultaneous next and prev cancel each other out.
  logic next_ev, prev_ev, btn_ev;
  assign next_ev = press_q[0] & ~press_q[1];
  assign prev_ev = press_q[1] & ~press_q[0];
  assign btn_ev  = next_ev | prev_ev;

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [1:0] cur_idx_q, cur_idx_d;
  logic       cur_blank_q, cur_blank_d;
  logic [1:0] tgt_idx_q, tgt_idx_d;
  logic       tgt_blank_q, tgt_blank_d;
  logic [2:0] ena_q, ena_d;
  logic       auto_step;
  logic [1:0] step_idx;

`ifdef SEQ_AUTO_EN
  localparam int DW_W = ($clog2(DWELL_FRAMES + 1) > 8) ? $clog2(DWELL_FRAMES + 1) : 8;
  localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(DWELL_FRAMES);

  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [DW_W-1:0] dwell_inc;

  assign dwell_inc = dwell_q + DW_W'(1);

  // Counts frames shown in SHOW while the slideshow runs unblanked. A button
  // press takes precedence: it drops any same-cycle auto step and restarts
  // the dwell so the viewer gets a full dwell on the chosen image.
  always_comb begin
    dwell_d   = dwell_q;
    auto_step = 1'b0;
    if (!auto_mode) begin
      dwell_d = '0;
    end else if (btn_ev) begin
      dwell_d = '0;
    end else if (state_q == ST_SHOW && !blank_req && fb) begin
      if (dwell_inc == DWELL_MAX) begin
        dwell_d   = '0;
        auto_step = 1'b1;
      end else begin
        dwell_d = dwell_inc;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) dwell_q <= '0;
    else        dwell_q <= dwell_d;
  end
`else
  logic unused_auto;
  assign unused_auto = auto_mode;
  assign auto_step   = 1'b0;
`endif

  // Steps always apply to the target, so several presses in one frame stack.
  always_comb begin
    step_idx = tgt_idx_q;
    if (next_ev)        step_idx = idx_inc(tgt_idx_q);
    else if (prev_ev)   step_idx = idx_dec(tgt_idx_q);
    else if (auto_step) step_idx = idx_inc(tgt_idx_q);
  end

  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    cur_blank_d = cur_blank_q;
    tgt_idx_d   = tgt_idx_q;
    tgt_blank_d = tgt_blank_q;
    ena_d       = ena_q;
    case (state_q)
      ST_INIT: begin
        if (fb) begin
          cur_idx_d   = 2'd0;
          tgt_idx_d   = 2'd0;
          cur_blank_d = 1'b0;
          tgt_blank_d = 1'b0;
          ena_d       = ena_code(2'd0, 1'b0);
          state_d     = ST_SHOW;
        end
      end
      ST_SHOW: begin
        // A request landing on a boundary cycle is not applied here; WAIT
        // commits it at the following boundary.
        if (btn_ev || auto_step || (blank_req != cur_blank_q)) begin
          tgt_idx_d   = step_idx;
          tgt_blank_d = blank_req;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        tgt_idx_d   = step_idx;
        tgt_blank_d = blank_req;
        // Commit including any same-cycle update so targets never go stale.
        if (fb) begin
          cur_idx_d   = tgt_idx_d;
          cur_blank_d = tgt_blank_d;
          ena_d       = ena_code(tgt_idx_d, tgt_blank_d);
          state_d     = ST_SHOW;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cur_idx_q   <= 2'd0;
      cur_blank_q <= 1'b0;
      tgt_idx_q   <= 2'd0;
      tgt_blank_q <= 1'b0;
      ena_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      cur_blank_q <= cur_blank_d;
      tgt_idx_q   <= tgt_idx_d;
      tgt_blank_q <= tgt_blank_d;
      ena_q       <= ena_d;
    end
  end

  assign ena       = ena_q;
  assign image_idx = cur_idx_q;
  assign pending   = (state_q == ST_WAIT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vga_image_sequencer.sv
// Directed testbench for vga_image_sequencer (DEBOUNCE_CYCLES=4,
// DWELL_FRAMES=3). Inputs change on the falling clock edge; outputs are
// sampled on the falling edge too, half a cycle away from the active edge.

module tb_vga_image_sequencer;

  localparam int DB = 4;
  localparam int DW = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_next, btn_prev, auto_mode, blank_req, vsync;
  logic [2:0] ena;
  logic [1:0] image_idx;
  logic       pending;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_image_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .DWELL_FRAMES   (DW)
  ) dut (
    .vga_clk  (clk),
    .rst_n    (rst_n),
    .btn_next (btn_next),
    .btn_prev (btn_prev),
    .auto_mode(auto_mode),
    .blank_req(blank_req),
    .vsync    (vsync),
    .ena      (ena),
    .image_idx(image_idx),
    .pending  (pending),
    .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame: vsync low for 5 cycles (boundary on the first), then high.
  task automatic do_frame();
    vsync = 1'b0;
    tick(5);
    vsync = 1'b1;
    tick(3);
  endtask

  // Clean press long enough to pass the debouncer, then clean release.
  task automatic press(input logic nxt, input logic prv);
    btn_next = nxt;
    btn_prev = prv;
    tick(DB + 6);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    tick(DB + 6);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; vsync = 1'b0;
    btn_next = 1'b0; btn_prev = 1'b0; auto_mode = 1'b0; blank_req = 1'b0;
    tick(3);
    checks++; if (ena !== 3'b000) begin errors++; $display("FAIL reset_ena: got %b want 000", ena); end
    checks++; if (image_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", image_idx); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", pending); end
    rst_n = 1'b1;
    tick(4);
    checks++; if (ena !== 3'b000) begin errors++; $display("FAIL vsync_low_release: got %b want 000", ena); end
    vsync = 1'b1;
    tick(3);
    checks++; if (ena !== 3'b000) begin errors++; $display("FAIL init_no_fb: got %b want 000", ena); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL init_pending: got %b want 0", pending); end
  endtask

  task automatic test_startup();
    vsync = 1'b0;
    checks++; if (ena !== 3'b000) begin errors++; $display("FAIL startup_before_fb: got %b want 000", ena); end
    tick(1);
    checks++; if (ena !== 3'b001) begin errors++; $display("FAIL startup_ena: got %b want 001", ena); end
    checks++; if (image_idx !== 2'd0) begin errors++; $display("FAIL startup_idx: got %0d want 0", image_idx); end
    tick(4);
    vsync = 1'b1;
    tick(3);
  endtask

  task automatic test_next_wrap();
    logic [2:0] exp_ena [3];
    logic [1:0] exp_idx [3];
    logic [2:0] prev_ena;
    exp_ena[0] = 3'b011; exp_ena[1] = 3'b111; exp_ena[2] = 3'b001;
    exp_idx[0] = 2'd1;   exp_idx[1] = 2'd2;   exp_idx[2] = 2'd0;
    prev_ena = 3'b001;
    for (int i = 0; i < 3; i++) begin
      press(1'b1, 1'b0);
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL next%0d_pending: got %b want 1", i, pending); end
      vsync = 1'b0;
      checks++; if (ena !== prev_ena) begin errors++; $display("FAIL next%0d_hold: got %b want %b", i, ena, prev_ena); end
      tick(1);
      checks++; if (ena !== exp_ena[i]) begin errors++; $display("FAIL next%0d_ena: got %b want %b", i, ena, exp_ena[i]); end
      checks++; if (image_idx !== exp_idx[i]) begin errors++; $display("FAIL next%0d_idx: got %0d want %0d", i, image_idx, exp_idx[i]); end
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL next%0d_pending_clr: got %b want 0", i, pending); end
      tick(4);
      vsync = 1'b1;
      tick(3);
      prev_ena = exp_ena[i];
    end
  endtask

  task automatic test_glitch();
    btn_prev = 1'b1;
    tick(3);
    btn_prev = 1'b0;
    tick(12);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL glitch_pending: got %b want 0", pending); end
    do_frame();
    checks++; if (ena !== 3'b001) begin errors++; $display("FAIL glitch_ena: got %b want 001", ena); end
  endtask

  task automatic test_prev();
    press(1'b0, 1'b1);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL prev_pending: got %b want 1", pending); end
    do_frame();
    checks++; if (ena !== 3'b111) begin errors++; $display("FAIL prev_wrap_ena: got %b want 111", ena); end
    checks++; if (image_idx !== 2'd2) begin errors++; $display("FAIL prev_wrap_idx: got %0d want 2", image_idx); end
    press(1'b1, 1'b0);
    do_frame();
    checks++; if (ena !== 3'b001) begin errors++; $display("FAIL prev_back0_ena: got %b want 001", ena); end
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    checks++; if (ena !== 3'b001) begin errors++; $display("FAIL prev_accum_hold: got %b want 001", ena); end
    do_frame();
    checks++; if (ena !== 3'b011) begin errors++; $display("FAIL prev_accum_ena: got %b want 011", ena); end
    checks++; if (image_idx !== 2'd1) begin errors++; $display("FAIL prev_accum_idx: got %0d want 1", image_idx); end
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b1);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL simul_pending: got %b want 0", pending); end
    checks++; if (ena !== 3'b011) begin errors++; $display("FAIL simul_ena: got %b want 011", ena); end
    do_frame();
    checks++; if (ena !== 3'b011) begin errors++; $display("FAIL simul_ena_fb: got %b want 011", ena); end
    checks++; if (image_idx !== 2'd1) begin errors++; $display("FAIL simul_idx: got %0d want 1", image_idx); end
  endtask

  task automatic test_blank();
    blank_req = 1'b1;
    tick(2);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL blank_pending: got %b want 1", pending); end
    checks++; if (ena !== 3'b011) begin errors++; $display("FAIL blank_hold: got %b want 011", ena); end
    do_frame();
    checks++; if (ena !== 3'b000) begin errors++; $display("FAIL blank_ena: got %b want 000", ena); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL blank_settled: got %b want 0", pending); end
    press(1'b1, 1'b0);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL blank_next_pending: got %b want 1", pending); end
    checks++; if (ena !== 3'b000) begin errors++; $display("FAIL blank_next_hold: got %b want 000", ena); end
    blank_req = 1'b0;
    tick(2);
    do_frame();
    checks++; if (ena !== 3'b111) begin errors++; $display("FAIL unblank_ena: got %b want 111", ena); end
    checks++; if (image_idx !== 2'd2) begin errors++; $display("FAIL unblank_idx: got %0d want 2", image_idx); end
  endtask

  // A request arriving on the boundary cycle itself waits one more frame.
  task automatic test_back_to_back();
    blank_req = 1'b1;
    vsync = 1'b0;
    tick(1);
    checks++; if (ena !== 3'b111) begin errors++; $display("FAIL fbreq_hold: got %b want 111", ena); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL fbreq_pending: got %b want 1", pending); end
    tick(4);
    vsync = 1'b1;
    tick(3);
    do_frame();
    checks++; if (ena !== 3'b000) begin errors++; $display("FAIL fbreq_ena: got %b want 000", ena); end
    blank_req = 1'b0;
    tick(2);
    do_frame();
    checks++; if (ena !== 3'b111) begin errors++; $display("FAIL fbreq_restore: got %b want 111", ena); end
  endtask

  task automatic test_auto();
`ifdef SEQ_AUTO_EN
    auto_mode = 1'b1;
    tick(2);
    for (int f = 1; f <= 3; f++) begin
      do_frame();
      checks++; if (ena !== 3'b111) begin errors++; $display("FAIL auto_dwell%0d: got %b want 111", f, ena); end
    end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL auto_step_pending: got %b want 1", pending); end
    do_frame();
    checks++; if (ena !== 3'b001) begin errors++; $display("FAIL auto_apply: got %b want 001", ena); end
    do_frame();
    do_frame();
    press(1'b1, 1'b0);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL auto_press_pending: got %b want 1", pending); end
    do_frame();
    checks++; if (ena !== 3'b011) begin errors++; $display("FAIL auto_press_ena: got %b want 011", ena); end
    for (int f = 1; f <= 3; f++) begin
      do_frame();
      checks++; if (ena !== 3'b011) begin errors++; $display("FAIL auto_restart%0d: got %b want 011", f, ena); end
    end
    do_frame();
    checks++; if (ena !== 3'b111) begin errors++; $display("FAIL auto_apply2: got %b want 111", ena); end
    do_frame();
    do_frame();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ena !== 3'b000) begin errors++; $display("FAIL auto_reset_ena: got %b want 000", ena); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL auto_reset_pending: got %b want 0", pending); end
    auto_mode = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    do_frame();
    checks++; if (ena !== 3'b001) begin errors++; $display("FAIL auto_restart_ena: got %b want 001", ena); end
`else
    auto_mode = 1'b1;
    tick(2);
    for (int f = 1; f <= 5; f++) begin
      do_frame();
      checks++; if (ena !== 3'b111) begin errors++; $display("FAIL noauto_ena%0d: got %b want 111", f, ena); end
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL noauto_pending%0d: got %b want 0", f, pending); end
    end
    auto_mode = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    press(1'b0, 1'b1);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rmid_pending: got %b want 1", pending); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ena !== 3'b000) begin errors++; $display("FAIL rmid_ena: got %b want 000", ena); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rmid_pending_clr: got %b want 0", pending); end
    checks++; if (image_idx !== 2'd0) begin errors++; $display("FAIL rmid_idx: got %0d want 0", image_idx); end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    do_frame();
    checks++; if (ena !== 3'b001) begin errors++; $display("FAIL rmid_discard_ena: got %b want 001", ena); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rmid_discard_pending: got %b want 0", pending); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_startup();
    test_next_wrap();
    test_glitch();
    test_prev();
    test_simultaneous();
    test_blank();
    test_back_to_back();
    test_auto();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
